// File: rtl/mul16_arbiter_if.sv
// mul16_arbiter_if: requester, response and multiplier-side signals of mul16_arbiter.
interface mul16_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [31:0]        rsp_product;
  logic               rsp_err;
  logic               mul_st;
  logic [15:0]        mul_mplier;
  logic [15:0]        mul_mcand;
  logic               mul_done;
  logic [31:0]        mul_product;
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_st, mul_mplier, mul_mcand
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, mul_st, mul_mplier, mul_mcand
  );
endinterface

// File: rtl/mul16_arbiter.sv
// mul16_arbiter: round-robin sharing of one sequential 16x16 multiplier between NREQ requesters.
// Optional BUSY watchdog enabled by defining MUL16_ARB_TIMEOUT_EN.
module mul16_arbiter #(
  parameter int NREQ           = 4,
  parameter int FLUSH_CYCLES   = 80,
  parameter int TIMEOUT_CYCLES = 40
) (
  input logic            clk,
  input logic            rst_n,
  mul16_arbiter_if.slave bus
);
  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {FLUSH, IDLE, START, BUSY, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] ptr_q, ptr_d, gnt, j;
  logic [IW-1:0] id_q;
  logic [15:0]   mplier_q, mcand_q;
  logic [31:0]   prod_q;
  logic          mul_st_q, rsp_valid_q, any;
`ifdef MUL16_ARB_TIMEOUT_EN
  logic          err_q;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
  assign any   = |bus.req_valid;
  assign ptr_d = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
  // Descending scan so the lowest cyclic offset from ptr_q wins.
  always_comb begin
    gnt = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_q) + k) % NREQ);
      if (bus.req_valid[j]) gnt = j;
    end
  end
  assign bus.req_ready   = (state_q == IDLE && any) ? NREQ'(1) << gnt : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
  assign bus.mul_st      = mul_st_q;
  assign bus.mul_mplier  = mplier_q;
  assign bus.mul_mcand   = mcand_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mul_st_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef MUL16_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      mul_st_q <= 1'b0;
      case (state_q)
        FLUSH: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        IDLE: if (any) begin
          mplier_q <= bus.req_a[16*gnt +: 16];
          mcand_q  <= bus.req_b[16*gnt +: 16];
          id_q     <= gnt;
          ptr_q    <= ptr_d;
          mul_st_q <= 1'b1;
          state_q  <= START;
        end
        START: begin
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          if (bus.mul_done) begin
            prod_q      <= bus.mul_product;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
`ifdef MUL16_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
`ifdef MUL16_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            prod_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else cnt_q <= cnt_q + CW'(1);
`endif
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cnt_q       <= '0;
`ifdef MUL16_ARB_TIMEOUT_EN
          state_q     <= err_q ? FLUSH : IDLE;
`else
          state_q     <= IDLE;
`endif
        end
        default: state_q <= FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_arbiter.sv
// tb_mul16_arbiter: randomized self-checking bench with a behavioural multiplier and round-robin model.
module tb_mul16_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mul16_arbiter_if #(.NREQ(NREQ)) bus ();
  mul16_arbiter #(.NREQ(NREQ), .FLUSH_CYCLES(80), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  logic [NREQ-1:0] vld = '0;
  logic [15:0] opa [NREQ];
  logic [15:0] opb [NREQ];
  logic rdy = 1'b0;
  bit hang = 1'b0;
  assign bus.req_valid = vld;
  assign bus.rsp_ready = rdy;
  for (genvar i = 0; i < NREQ; i++) begin : g_pk
    assign bus.req_a[16*i +: 16] = opa[i];
    assign bus.req_b[16*i +: 16] = opb[i];
  end
  // Behavioural sequential multiplier: done lands 17+popcount(a) cycles after the st cycle.
  int cyc = 0;
  int done_at = -1;
  int opchg = 0;
  bit mbusy = 1'b0;
  logic [15:0] ma = '0, mb = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mul_st) begin
      done_at <= cyc + 17 + $countones(bus.mul_mplier);
      ma <= bus.mul_mplier;
      mb <= bus.mul_mcand;
      mbusy <= 1'b1;
    end else if (mbusy && (!rst_n || cyc >= done_at)) mbusy <= 1'b0;
    else if (mbusy && (bus.mul_mplier !== ma || bus.mul_mcand !== mb)) opchg <= opchg + 1;
  end
  assign bus.mul_done = !hang && (cyc == done_at);
  assign bus.mul_product = bus.mul_done ? 32'(ma) * 32'(mb) : 32'hDEAD_BEEF;
  int st_cnt = 0, st_multi = 0, rdy_cnt = 0, oh_bad = 0;
  logic st_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.mul_st) st_cnt <= st_cnt + 1;
    if (bus.mul_st && st_prev) st_multi <= st_multi + 1;
    st_prev <= bus.mul_st;
    if (|bus.req_ready) rdy_cnt <= rdy_cnt + 1;
    if (!$onehot0(bus.req_ready) || (bus.req_ready & ~vld) != '0) oh_bad <= oh_bad + 1;
  end
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  // Drives one transaction: waits for a grant, optionally drops that valid, waits for the
  // response, holds rsp_ready low for 'hold' cycles, then handshakes. Ends 1ns after a posedge.
  task automatic serve(input int hold, input bit keep, output bit got_r, output int gid,
                       output int lat, output logic [31:0] prod, output int id, output bit err,
                       output int chg, output int wt);
    got_r = 0; gid = -1; lat = -1; prod = 'x; id = -1; err = 0; chg = 0; wt = -1;
    for (int c = 0; c < 300 && !got_r; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        got_r = 1;
        wt = c + 1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
      end
    end
    if (!got_r) return;
    @(posedge clk);
    #1 if (!keep) vld[gid] = 1'b0;
    for (int c = 1; c < 150 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat = c;
    end
    if (lat < 0) return;
    prod = bus.rsp_product;
    id = int'(bus.rsp_id);
    err = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_product !== prod || int'(bus.rsp_id) != id || bus.rsp_err !== err) chg++;
    end
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
  endtask
  task automatic test_reset();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    logic [71:0] outs;
    opa[0] = 16'd7; opb[0] = 16'd9; vld = 4'b0001;
    #1 rst_n = 1'b0;
    #2 outs = {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err, bus.mul_st, bus.mul_mplier, bus.mul_mcand};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ptr_m = 0;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (wt != 80) begin bad++; $display("FAIL reset_flush_len: got %0d want 80", wt); end
    total++; if (g != 0 || id != 0) begin bad++; $display("FAIL reset_first_grant: got %0d/%0d want 0", g, id); end
    total++; if (p !== 32'd63) begin bad++; $display("FAIL reset_first_product: got %0d want 63", p); end
    ptr_m = 1;
  endtask
  task automatic test_single();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    int s0, r0;
    s0 = st_cnt; r0 = rdy_cnt;
    opa[2] = 16'h1234; opb[2] = 16'h5678; vld = 4'b0100;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (!got || g != 2) begin bad++; $display("FAIL single_grant: got %0d want 2", g); end
    total++; if (p !== 32'h0626_0060) begin bad++; $display("FAIL single_product: got %h want 06260060", p); end
    total++; if (id != 2) begin bad++; $display("FAIL single_id: got %0d want 2", id); end
    total++; if (lat != 24) begin bad++; $display("FAIL single_latency: got %0d want 24", lat); end
    total++; if (rdy_cnt - r0 != 1 || st_cnt - s0 != 1) begin
      bad++; $display("FAIL single_pulses: ready=%0d st=%0d want 1/1", rdy_cnt - r0, st_cnt - s0); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", e); end
    ptr_m = 3;
  endtask
  task automatic test_latency();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    opa[0] = 16'h0000; opb[0] = 16'hFFFF; vld = 4'b0001;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (p !== 32'd0 || lat != 19) begin bad++; $display("FAIL lat_zero: got %h/%0d want 0/19", p, lat); end
    opa[3] = 16'hFFFF; opb[3] = 16'hFFFF; vld = 4'b1000;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (p !== 32'hFFFE_0001 || lat != 35) begin bad++; $display("FAIL lat_full: got %h/%0d want fffe0001/35", p, lat); end
    total++; if (id != 3) begin bad++; $display("FAIL lat_full_id: got %0d want 3", id); end
    ptr_m = 0;
  endtask
  task automatic test_backpressure();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    int s0, r0, eg, og;
    opa[1] = 16'($urandom); opb[1] = 16'($urandom);
    opa[3] = 16'($urandom); opb[3] = 16'($urandom);
    vld = 4'b1010;
    eg = rr_pick(ptr_m, vld);
    og = (eg == 1) ? 3 : 1;
    s0 = st_cnt; r0 = rdy_cnt;
    serve(10, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (g != eg || id != eg) begin bad++; $display("FAIL bp_grant: got %0d/%0d want %0d", g, id, eg); end
    total++; if (chg != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", chg); end
    total++; if (rdy_cnt - r0 != 1 || st_cnt - s0 != 1) begin
      bad++; $display("FAIL bp_no_new_op: ready=%0d st=%0d want 1/1", rdy_cnt - r0, st_cnt - s0); end
    total++; if (p !== 32'(opa[eg]) * 32'(opb[eg])) begin bad++; $display("FAIL bp_product: got %h want %h", p, 32'(opa[eg]) * 32'(opb[eg])); end
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (g != og || p !== 32'(opa[og]) * 32'(opb[og])) begin
      bad++; $display("FAIL bp_second: got %0d/%h want %0d/%h", g, p, og, 32'(opa[og]) * 32'(opb[og])); end
    ptr_m = (og + 1) % NREQ;
  endtask
  task automatic test_random();
    bit got, e; int g, lat, id, chg, wt, eg; logic [31:0] p, ep;
    logic [NREQ-1:0] nw;
    for (int n = 0; n < 20; n++) begin
      nw = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ((vld | nw) == '0) nw[$urandom_range(0, NREQ - 1)] = 1'b1;
      for (int i = 0; i < NREQ; i++) if (nw[i] && !vld[i]) begin
        case ($urandom_range(0, 3))
          0: opa[i] = 16'hFFFF;
          1: opa[i] = 16'h0000;
          default: opa[i] = 16'($urandom);
        endcase
        opb[i] = 16'($urandom);
      end
      vld = vld | nw;
      eg = rr_pick(ptr_m, vld);
      ep = 32'(opa[eg]) * 32'(opb[eg]);
      serve($urandom_range(0, 3), 0, got, g, lat, p, id, e, chg, wt);
      total++; if (g != eg || id != eg) begin bad++; $display("FAIL rand_grant[%0d]: got %0d/%0d want %0d", n, g, id, eg); end
      total++; if (p !== ep || e !== 1'b0) begin bad++; $display("FAIL rand_product[%0d]: got %h err=%b want %h", n, p, e, ep); end
      total++; if (lat != 19 + $countones(opa[eg]) || chg != 0) begin
        bad++; $display("FAIL rand_timing[%0d]: got lat=%0d chg=%0d want %0d/0", n, lat, chg, 19 + $countones(opa[eg])); end
      ptr_m = (eg + 1) % NREQ;
    end
    vld = '0;
    total++; if (oh_bad != 0 || opchg != 0 || st_multi != 0) begin
      bad++; $display("FAIL protocol: onehot=%0d opchg=%0d st_multi=%0d want 0", oh_bad, opchg, st_multi); end
  endtask
  task automatic test_round_robin();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 16'($urandom) | 16'(1 << i);
      opb[i] = 16'($urandom);
    end
    vld = '1;
    for (int n = 0; n < 5; n++) begin
      serve(0, 1, got, g, lat, p, id, e, chg, wt);
      if (n == 4) vld = '0;
      total++; if (g != exp_ord[n] || id != exp_ord[n] || rr_pick(ptr_m, 4'hF) != exp_ord[n]) begin
        bad++; $display("FAIL rr_order[%0d]: got %0d/%0d want %0d", n, g, id, exp_ord[n]); end
      total++; if (p !== 32'(opa[exp_ord[n]]) * 32'(opb[exp_ord[n]])) begin
        bad++; $display("FAIL rr_product[%0d]: got %h want %h", n, p, 32'(opa[exp_ord[n]]) * 32'(opb[exp_ord[n]])); end
      ptr_m = (exp_ord[n] + 1) % NREQ;
    end
  endtask
  task automatic test_reset_mid_busy();
    bit got, e, seen; int g, lat, id, chg, wt, s0, r0, rv; logic [31:0] p;
    logic [71:0] outs;
    opa[0] = 16'($urandom) | 16'h00FF; opb[0] = 16'($urandom); vld = 4'b0001;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); seen = |bus.req_ready; end
    @(posedge clk);
    #1 vld = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.mul_st; end
    total++; if (!seen) begin bad++; $display("FAIL midrst_st: got no st want st"); end
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1 outs = {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err, bus.mul_st, bus.mul_mplier, bus.mul_mcand};
    total++; if (outs !== '0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", outs); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
    opa[1] = 16'd3; opb[1] = 16'd5; vld = 4'b0010;
    s0 = st_cnt; r0 = rdy_cnt; rv = 0;
    for (int c = 0; c < 80; c++) begin @(negedge clk); if (bus.rsp_valid) rv++; end
    total++; if (st_cnt != s0 || rdy_cnt != r0 || rv != 0) begin
      bad++; $display("FAIL midrst_flush: st=%0d ready=%0d rsp=%0d want 0/0/0", st_cnt - s0, rdy_cnt - r0, rv); end
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (wt != 1 || g != 1) begin bad++; $display("FAIL midrst_grant: got wt=%0d g=%0d want 1/1", wt, g); end
    total++; if (p !== 32'd15 || id != 1) begin bad++; $display("FAIL midrst_product: got %0d/%0d want 15/1", p, id); end
    ptr_m = 2;
  endtask
`ifdef MUL16_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit got, e; int g, lat, id, chg, wt; logic [31:0] p;
    hang = 1'b1;
    opa[0] = 16'h00F0; opb[0] = 16'h1111; vld = 4'b0001;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    hang = 1'b0;
    total++; if (lat != 42) begin bad++; $display("FAIL timeout_latency: got %0d want 42", lat); end
    total++; if (e !== 1'b1 || p !== 32'd0) begin bad++; $display("FAIL timeout_resp: got err=%b prod=%h want 1/0", e, p); end
    opa[2] = 16'd11; opb[2] = 16'd13; vld = 4'b0100;
    serve(0, 0, got, g, lat, p, id, e, chg, wt);
    total++; if (wt != 81) begin bad++; $display("FAIL timeout_reflush: got %0d want 81", wt); end
    total++; if (p !== 32'd143 || e !== 1'b0) begin bad++; $display("FAIL timeout_after: got %0d err=%b want 143/0", p, e); end
    ptr_m = 3;
  endtask
`endif
  initial begin
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    test_reset();
    test_single();
    test_latency();
    test_backpressure();
    test_random();
    test_round_robin();
    test_reset_mid_busy();
`ifdef MUL16_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
